// File: rtl/alu_cmd_pkg.sv
// rtl/alu_cmd_pkg.sv - shared opcodes, state encoding and widths for the ALU command driver
package alu_cmd_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_OR    = 3'b000;
  localparam logic [OP_W-1:0] OP_AND   = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] OP_MIN   = 3'b100;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'b101;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'b110;
  localparam logic [OP_W-1:0] OP_READ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Opcodes 000..100 are executed by the external ALU; the rest are local.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op <= OP_MIN);
  endfunction

endpackage

// File: rtl/alu_cmd_ref.sv
// rtl/alu_cmd_ref.sv - combinational expected-result model of the 4-bit ALU
//   a_i, b_i : operands
//   s_i      : ALU select (OR/AND/ADD/SUB/MIN)
//   y_o      : expected ALU result, modulo 16; unsigned MIN
module alu_cmd_ref
  import alu_cmd_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   s_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (s_i)
      OP_OR:   y_o = a_i | b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_MIN:  y_o = (a_i < b_i) ? a_i : b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - accumulator command driver for a 4-bit combinational ALU
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake
//   res_valid/res_ready/res_data/res_err : response handshake, res_data = new accumulator
//   alu_a/alu_b/alu_s (out), alu_o (in) : registered ALU drive, combinational return
//   Optional macro ALU_CMD_DRIVER_SELFCHECK_EN: checks alu_o against alu_cmd_ref,
//   reported on res_err; otherwise res_err is tied 0.
module alu_cmd_driver
  import alu_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_s,
  input  logic [DATA_W-1:0] alu_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_s_q, alu_s_d;
  logic              cmd_ready_q;
  logic              res_valid_q;
  logic              cmd_accept;

  // cmd_ready_q is only ever high in IDLE, so it alone qualifies the accept.
  assign cmd_accept = cmd_valid & cmd_ready_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_accept) state_d = is_alu_op(cmd_op) ? ISSUE : RESP;
      ISSUE:   state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    acc_d      = acc_q;
    res_data_d = res_data_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    if (state_q == IDLE && cmd_accept) begin
      if (is_alu_op(cmd_op)) begin
        alu_a_d = acc_q;
        alu_b_d = cmd_data;
        alu_s_d = cmd_op;
      end else begin
        case (cmd_op)
          OP_LOAD:  acc_d = cmd_data;
          OP_CLEAR: acc_d = '0;
          default:  acc_d = acc_q;
        endcase
        res_data_d = acc_d;
      end
    end else if (state_q == ISSUE) begin
      acc_d      = alu_o;
      res_data_d = alu_o;
    end
  end

  // Every output is registered; ready/valid follow the state being entered
  // so they line up with the state register one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      res_data_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      cmd_ready_q <= (state_d == IDLE);
      res_valid_q <= (state_d == RESP);
    end
  end

`ifdef ALU_CMD_DRIVER_SELFCHECK_EN
  logic [DATA_W-1:0] ref_y;
  logic              res_err_q;

  alu_cmd_ref u_ref (
    .a_i (alu_a_q),
    .b_i (alu_b_q),
    .s_i (alu_s_q),
    .y_o (ref_y)
  );

  // Updated at the ISSUE capture edge, cleared by local commands, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_err_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      res_err_q <= (alu_o != ref_y);
    end else if (cmd_accept && !is_alu_op(cmd_op)) begin
      res_err_q <= 1'b0;
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - directed self-checking bench for alu_cmd_driver
module tb_alu_cmd_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_err;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_s;
  logic [3:0] alu_o;
  logic       alu_fault = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_o     (alu_o)
  );

  // Bench-side ALU, with an injectable stuck-at-zero fault.
  always_comb begin
    alu_o = 4'd0;
    case (alu_s)
      3'b000: alu_o = alu_a | alu_b;
      3'b001: alu_o = alu_a & alu_b;
      3'b010: alu_o = alu_a + alu_b;
      3'b011: alu_o = alu_a - alu_b;
      3'b100: alu_o = (alu_a < alu_b) ? alu_a : alu_b;
      default: alu_o = 4'd0;
    endcase
    if (alu_fault) alu_o = 4'd0;
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [3:0] d);
    int n = 0;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cmd_ready) check_eq("accept_timeout", 8'd0, 8'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic [3:0] exp);
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, {7'd0, res_valid}, 8'd1);
    check_eq(tag, {4'd0, res_data}, {4'd0, exp});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [3:0] d,
                        input logic [3:0] exp);
    send_cmd(op, d);
    wait_resp(tag, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, {7'd0, cmd_ready}, 8'd0);
    check_eq({tag, "_res_valid"}, {7'd0, res_valid}, 8'd0);
    check_eq({tag, "_res_data"}, {4'd0, res_data}, 8'd0);
    check_eq({tag, "_res_err"}, {7'd0, res_err}, 8'd0);
    check_eq({tag, "_alu_a"}, {4'd0, alu_a}, 8'd0);
    check_eq({tag, "_alu_b"}, {4'd0, alu_b}, 8'd0);
    check_eq({tag, "_alu_s"}, {5'd0, alu_s}, 8'd0);
  endtask

  logic [2:0] bb_op[7];
  logic [3:0] bb_dat[7];
  logic [3:0] bb_exp[7];
  int         bb_gap[6];
  int         acc_cyc[$];
  logic [3:0] resp_q[$];

  initial begin
    // Reset state
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    check_eq("rdy_before_edge", {7'd0, cmd_ready}, 8'd0);
    tick();
    check_eq("rdy_after_edge", {7'd0, cmd_ready}, 8'd1);

    // LOAD 9: response right after the accept edge
    send_cmd(3'b101, 4'd9);
    check_eq("load9_valid_t0", {7'd0, res_valid}, 8'd1);
    check_eq("load9_rdy_low", {7'd0, cmd_ready}, 8'd0);
    wait_resp("load9", 4'd9);
    check_eq("hs_valid_low", {7'd0, res_valid}, 8'd0);
    check_eq("hs_rdy_high", {7'd0, cmd_ready}, 8'd1);

    // ADD 9: ISSUE cycle then response, 9+9 = 2
    send_cmd(3'b010, 4'd9);
    check_eq("add_issue_valid", {7'd0, res_valid}, 8'd0);
    check_eq("add_alu_a", {4'd0, alu_a}, 8'd9);
    check_eq("add_alu_b", {4'd0, alu_b}, 8'd9);
    check_eq("add_alu_s", {5'd0, alu_s}, 8'd2);
    tick();
    check_eq("add_valid_t1", {7'd0, res_valid}, 8'd1);
    wait_resp("add9", 4'd2);

    // Arithmetic chain
    do_cmd("load3", 3'b101, 4'd3, 4'd3);
    do_cmd("sub5", 3'b011, 4'd5, 4'd14);
    do_cmd("min7", 3'b100, 4'd7, 4'd7);
    do_cmd("or1", 3'b000, 4'd1, 4'd7);
    do_cmd("and6", 3'b001, 4'd6, 4'd6);
    // LOAD must leave the ALU drive untouched (last ALU op was AND with b=6)
    do_cmd("load5", 3'b101, 4'd5, 4'd5);
    check_eq("load_hold_b", {4'd0, alu_b}, 8'd6);
    check_eq("load_hold_s", {5'd0, alu_s}, 8'd1);

    // CLEAR, then READ stalled by res_ready low; a stray command is ignored
    do_cmd("clear", 3'b110, 4'd9, 4'd0);
    send_cmd(3'b111, 4'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        cmd_op = 3'b101;
        cmd_data = 4'd5;
        cmd_valid = 1'b1;
      end
      check_eq("stall_valid", {7'd0, res_valid}, 8'd1);
      check_eq("stall_data", {4'd0, res_data}, 8'd0);
      check_eq("stall_rdy", {7'd0, cmd_ready}, 8'd0);
      tick();
    end
    cmd_valid = 1'b0;
    wait_resp("read_stalled", 4'd0);
    do_cmd("read_after_stray", 3'b111, 4'd0, 4'd0);

    // Reset asserted during ISSUE of ADD
    do_cmd("load6", 3'b101, 4'd6, 4'd6);
    send_cmd(3'b010, 4'd3);
    check_eq("abort_alu_b_pre", {4'd0, alu_b}, 8'd3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("abort_no_resp", {7'd0, res_valid}, 8'd0);
    check_eq("abort_rdy", {7'd0, cmd_ready}, 8'd1);
    do_cmd("read_after_abort", 3'b111, 4'd0, 4'd0);
    do_cmd("load4", 3'b101, 4'd4, 4'd4);

    // Self-check error reporting
    do_cmd("load1", 3'b101, 4'd1, 4'd1);
`ifdef ALU_CMD_DRIVER_SELFCHECK_EN
    alu_fault = 1'b1;
    send_cmd(3'b010, 4'd1);
    tick();
    alu_fault = 1'b0;
    check_eq("fault_err", {7'd0, res_err}, 8'd1);
    wait_resp("fault_data", 4'd0);
    check_eq("fault_err_hold", {7'd0, res_err}, 8'd1);
    send_cmd(3'b111, 4'd0);
    check_eq("read_err_clr", {7'd0, res_err}, 8'd0);
    wait_resp("read_after_fault", 4'd0);
    do_cmd("load1b", 3'b101, 4'd1, 4'd1);
`endif
    send_cmd(3'b010, 4'd1);
    tick();
    check_eq("good_add_err", {7'd0, res_err}, 8'd0);
    wait_resp("good_add", 4'd2);

    // Back-to-back with res_ready tied high
    bb_op  = '{3'b101, 3'b010, 3'b010, 3'b111, 3'b111, 3'b011, 3'b111};
    bb_dat = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd1, 4'd0};
    bb_exp = '{4'd1, 4'd3, 4'd6, 4'd6, 4'd6, 4'd5, 4'd5};
    bb_gap = '{2, 3, 3, 2, 2, 3};
    begin
      int idx = 0;
      int cyc = 0;
      res_ready = 1'b1;
      cmd_op = bb_op[0];
      cmd_data = bb_dat[0];
      cmd_valid = 1'b1;
      while ((idx < 7 || resp_q.size() < 7) && cyc < 60) begin
        logic acc_now;
        acc_now = cmd_valid && cmd_ready;
        if (res_valid) resp_q.push_back(res_data);
        tick();
        cyc++;
        if (acc_now) begin
          acc_cyc.push_back(cyc);
          idx++;
          if (idx < 7) begin
            cmd_op = bb_op[idx];
            cmd_data = bb_dat[idx];
          end else begin
            cmd_valid = 1'b0;
          end
        end
      end
      cmd_valid = 1'b0;
      repeat (4) begin
        if (res_valid) resp_q.push_back(res_data);
        tick();
      end
      res_ready = 1'b0;
    end
    check_eq("bb_accepts", acc_cyc.size()[7:0], 8'd7);
    check_eq("bb_resps", resp_q.size()[7:0], 8'd7);
    for (int i = 0; i < 6; i++) begin
      if (i + 1 < acc_cyc.size())
        check_eq($sformatf("bb_gap%0d", i), 8'(acc_cyc[i+1] - acc_cyc[i]), 8'(bb_gap[i]));
    end
    for (int i = 0; i < 7; i++) begin
      if (i < resp_q.size())
        check_eq($sformatf("bb_resp%0d", i), {4'd0, resp_q[i]}, {4'd0, bb_exp[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
